// File: rtl/bp_perf_monitor.sv
// Branch-prediction performance monitor: per-channel saturating branch/miss
// counters with windowed miss statistics, end-of-program drain and a read port.

module bp_perf_ch #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         cnt_en,
  input  logic         wrap,
  input  logic         br,
  input  logic         miss,
  output logic [W-1:0] br_cnt,
  output logic [W-1:0] miss_cnt,
  output logic [W-1:0] win_last,
  output logic [W-1:0] win_worst,
  output logic         ovf
);
  logic         br_inc, miss_inc, ovf_set;
  logic [W-1:0] acc, acc_nxt;

  // A miss without a resolved branch is a protocol error and never counts.
  assign br_inc   = cnt_en & br;
  assign miss_inc = cnt_en & br & miss;

  always_comb begin
    acc_nxt = acc;
    if (miss_inc && !(&acc)) acc_nxt = acc + 1'b1;
    ovf_set = (br_inc & (&br_cnt)) | (miss_inc & (&miss_cnt)) | (miss_inc & (&acc));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      br_cnt    <= '0;
      miss_cnt  <= '0;
      acc       <= '0;
      win_last  <= '0;
      win_worst <= '0;
      ovf       <= 1'b0;
    end else if (clr) begin
      br_cnt    <= '0;
      miss_cnt  <= '0;
      acc       <= '0;
      win_last  <= '0;
      win_worst <= '0;
      ovf       <= 1'b0;
    end else begin
      if (br_inc && !(&br_cnt))     br_cnt   <= br_cnt + 1'b1;
      if (miss_inc && !(&miss_cnt)) miss_cnt <= miss_cnt + 1'b1;
      if (ovf_set)                  ovf      <= 1'b1;
      // The wrap cycle's own miss closes into the ending window.
      if (wrap) begin
        win_last <= acc_nxt;
        if (acc_nxt > win_worst) win_worst <= acc_nxt;
        acc <= '0;
      end else begin
        acc <= acc_nxt;
      end
    end
  end
endmodule

module bp_perf_monitor #(
  parameter int          NUM_CH       = 4,
  parameter int          CNT_WIDTH    = 32,
  parameter int          WIN_LOG2     = 10,
  parameter logic [31:0] HALT_INSN    = 32'h0000_0073,
  parameter int          DRAIN_CYCLES = 3,
  localparam int         CH_W         = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 en_i,
  input  logic                 clr_i,
  input  logic [NUM_CH-1:0]    br_instr_i,
  input  logic [NUM_CH-1:0]    br_miss_i,
  input  logic [31:0]          instr_i,
  input  logic                 rd_req_i,
  input  logic [CH_W-1:0]      rd_ch_i,
  input  logic [1:0]           rd_sel_i,
  output logic                 rd_vld_o,
  output logic [CNT_WIDTH-1:0] rd_data_o,
  output logic [CNT_WIDTH-1:0] cyc_cnt_o,
  output logic [NUM_CH-1:0]    ovf_o,
  output logic                 err_o,
  output logic [1:0]           state_o
);
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  typedef struct packed {
    logic                 vld;
    logic [CNT_WIDTH-1:0] data;
  } rd_rsp_t;

  logic [1:0]                         state;
  logic [3:0]                         drain_cnt;
  logic [WIN_LOG2-1:0]                win_cyc;
  logic                               counting, wrap, cyc_ovf, err, ch_ok;
  rd_rsp_t                            rsp_q;
  logic [CNT_WIDTH-1:0]               rd_mux;
  logic [NUM_CH-1:0][CNT_WIDTH-1:0]   br_cnt, miss_cnt, win_last, win_worst;
  logic [NUM_CH-1:0]                  ch_ovf;

  assign counting = (state == S_RUN) || (state == S_DRAIN);
  assign wrap     = counting && (&win_cyc);

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    bp_perf_ch #(.W(CNT_WIDTH)) u_ch (
      .clk      (clk_i),
      .rst      (rst_i),
      .clr      (clr_i),
      .cnt_en   (counting),
      .wrap     (wrap),
      .br       (br_instr_i[g]),
      .miss     (br_miss_i[g]),
      .br_cnt   (br_cnt[g]),
      .miss_cnt (miss_cnt[g]),
      .win_last (win_last[g]),
      .win_worst(win_worst[g]),
      .ovf      (ch_ovf[g])
    );
  end

  // Decoder-style mux keeps out-of-range channel indices from touching the arrays.
  always_comb begin
    rd_mux = '0;
    ch_ok  = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (rd_ch_i == CH_W'(i)) begin
        ch_ok = 1'b1;
        case (rd_sel_i)
          2'd0: rd_mux = br_cnt[i];
          2'd1: rd_mux = miss_cnt[i];
          2'd2: rd_mux = win_last[i];
          2'd3: rd_mux = win_worst[i];
        endcase
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state     <= S_IDLE;
      drain_cnt <= '0;
      win_cyc   <= '0;
      cyc_cnt_o <= '0;
      cyc_ovf   <= 1'b0;
      err       <= 1'b0;
      rsp_q     <= '0;
    end else if (clr_i) begin
      state     <= S_IDLE;
      drain_cnt <= '0;
      win_cyc   <= '0;
      cyc_cnt_o <= '0;
      cyc_ovf   <= 1'b0;
      err       <= 1'b0;
      rsp_q     <= '0;
    end else begin
      case (state)
        S_IDLE:  if (en_i) state <= S_RUN;
        S_RUN:   if (instr_i == HALT_INSN) begin
                   state     <= S_DRAIN;
                   drain_cnt <= '0;
                 end
        S_DRAIN: if (drain_cnt == 4'(DRAIN_CYCLES - 1)) state <= S_DONE;
                 else drain_cnt <= drain_cnt + 1'b1;
        default: ;
      endcase
      if (counting) begin
        win_cyc <= win_cyc + 1'b1;
        if (&cyc_cnt_o) cyc_ovf   <= 1'b1;
        else            cyc_cnt_o <= cyc_cnt_o + 1'b1;
      end
      if ((counting && |(br_miss_i & ~br_instr_i)) || (rd_req_i && !ch_ok)) err <= 1'b1;
      rsp_q.vld <= rd_req_i;
      if (rd_req_i) rsp_q.data <= ch_ok ? rd_mux : '0;
    end
  end

  always_comb begin
    ovf_o    = ch_ovf;
    ovf_o[0] = ch_ovf[0] | cyc_ovf;
  end

  assign rd_vld_o  = rsp_q.vld;
  assign rd_data_o = rsp_q.data;
  assign err_o     = err;
  assign state_o   = state;
endmodule

// File: tb/tb_bp_perf_monitor.sv
// Directed bench for bp_perf_monitor: a 4-channel, 8-bit, 4-cycle-window
// instance for function checks, plus a 3-channel instance for bad-channel reads.

module tb_bp_perf_monitor;
  logic        clk = 1'b0;
  logic        rst, en, clr, rd_req;
  logic [3:0]  br_instr, br_miss;
  logic [31:0] instr;
  logic [1:0]  rd_ch, rd_sel;

  logic        rd_vld, err;
  logic [7:0]  rd_data, cyc_cnt;
  logic [3:0]  ovf;
  logic [1:0]  state;

  logic        u1_rd_vld, u1_err;
  logic [7:0]  u1_rd_data, u1_cyc_cnt;
  logic [2:0]  u1_ovf;
  logic [1:0]  u1_state;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  bp_perf_monitor #(.NUM_CH(4), .CNT_WIDTH(8), .WIN_LOG2(2), .DRAIN_CYCLES(3)) u0 (
    .clk_i(clk), .rst_i(rst), .en_i(en), .clr_i(clr),
    .br_instr_i(br_instr), .br_miss_i(br_miss), .instr_i(instr),
    .rd_req_i(rd_req), .rd_ch_i(rd_ch), .rd_sel_i(rd_sel),
    .rd_vld_o(rd_vld), .rd_data_o(rd_data), .cyc_cnt_o(cyc_cnt),
    .ovf_o(ovf), .err_o(err), .state_o(state)
  );

  // Channel index 3 is out of range here.
  bp_perf_monitor #(.NUM_CH(3), .CNT_WIDTH(8), .WIN_LOG2(2), .DRAIN_CYCLES(3)) u1 (
    .clk_i(clk), .rst_i(rst), .en_i(en), .clr_i(clr),
    .br_instr_i(br_instr[2:0]), .br_miss_i(br_miss[2:0]), .instr_i(instr),
    .rd_req_i(rd_req), .rd_ch_i(rd_ch), .rd_sel_i(rd_sel),
    .rd_vld_o(u1_rd_vld), .rd_data_o(u1_rd_data), .cyc_cnt_o(u1_cyc_cnt),
    .ovf_o(u1_ovf), .err_o(u1_err), .state_o(u1_state)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  task automatic rd(input logic [1:0] ch, input logic [1:0] sel, input int exp, input string nm);
    rd_req = 1'b1; rd_ch = ch; rd_sel = sel;
    tick();
    rd_req = 1'b0;
    chk({nm, "_vld"}, 32'(rd_vld), 32'd1);
    chk(nm, 32'(rd_data), exp);
  endtask

  typedef struct {
    logic [1:0] ch;
    logic [1:0] sel;
    int         exp;
    string      nm;
  } rd_vec_t;

  typedef struct {
    logic       miss0;
    logic       err2;
    logic       req;
    logic [1:0] ch;
    logic [1:0] sel;
    int         exp;
  } cyc_vec_t;

  rd_vec_t  basic_tab[10];
  cyc_vec_t win_tab[20];

  initial begin
    // Reads after the 20-branch program: ch0/ch2 miss on 10 cycles.
    // Windows of ch0: 4,4,2,0,0 and the last drain-aligned window 0.
    basic_tab[0] = '{2'd0, 2'd0, 20, "ch0_br"};
    basic_tab[1] = '{2'd0, 2'd1, 10, "ch0_miss"};
    basic_tab[2] = '{2'd2, 2'd0, 20, "ch2_br"};
    basic_tab[3] = '{2'd2, 2'd1, 10, "ch2_miss"};
    basic_tab[4] = '{2'd1, 2'd1, 0,  "ch1_miss"};
    basic_tab[5] = '{2'd3, 2'd1, 0,  "ch3_miss"};
    basic_tab[6] = '{2'd1, 2'd0, 20, "ch1_br"};
    basic_tab[7] = '{2'd3, 2'd0, 20, "ch3_br"};
    basic_tab[8] = '{2'd0, 2'd2, 0,  "ch0_win_last"};
    basic_tab[9] = '{2'd0, 2'd3, 4,  "ch0_win_worst"};

    // Per counted cycle k: ch0 misses 3,1,4 in windows 0..2 (k=3 and k=7 are
    // wrap cycles), ch1 branches every cycle, ch2 protocol error at k=18.
    for (int k = 0; k < 20; k++) win_tab[k] = '{1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 0};
    foreach (win_tab[k]) if (k inside {1, 2, 3, 7, 8, 9, 10, 11}) win_tab[k].miss0 = 1'b1;
    win_tab[4]  = '{1'b0, 1'b0, 1'b1, 2'd0, 2'd2, 3};
    win_tab[5]  = '{1'b0, 1'b0, 1'b1, 2'd0, 2'd3, 3};
    win_tab[8]  = '{1'b1, 1'b0, 1'b1, 2'd0, 2'd2, 1};
    win_tab[9]  = '{1'b1, 1'b0, 1'b1, 2'd0, 2'd3, 3};
    win_tab[12] = '{1'b0, 1'b0, 1'b1, 2'd0, 2'd2, 4};
    win_tab[13] = '{1'b0, 1'b0, 1'b1, 2'd0, 2'd3, 4};
    win_tab[14] = '{1'b0, 1'b0, 1'b1, 2'd0, 2'd1, 8};
    win_tab[15] = '{1'b0, 1'b0, 1'b1, 2'd1, 2'd0, 15};
    win_tab[16] = '{1'b0, 1'b0, 1'b1, 2'd1, 2'd0, 16};
    win_tab[17] = '{1'b0, 1'b0, 1'b1, 2'd1, 2'd0, 17};
    win_tab[18] = '{1'b0, 1'b1, 1'b0, 2'd0, 2'd0, 0};
    win_tab[19] = '{1'b0, 1'b0, 1'b1, 2'd2, 2'd1, 0};

    rst = 1'b1; en = 1'b0; clr = 1'b0; rd_req = 1'b0;
    br_instr = '0; br_miss = '0; instr = '0; rd_ch = '0; rd_sel = '0;
    repeat (2) tick();
    rst = 1'b0;
    chk("reset_state", 32'(state), 32'd0);
    chk("reset_cyc", 32'(cyc_cnt), 32'd0);
    chk("reset_ovf", 32'(ovf), 32'd0);
    chk("reset_err", 32'(err), 32'd0);
    chk("reset_rd", {23'd0, rd_vld, rd_data}, 32'd0);

    // Asynchronous reset in the middle of a run.
    en = 1'b1; tick(); en = 1'b0;
    br_instr = 4'b0001;
    repeat (50) tick();
    chk("midrun_cyc", 32'(cyc_cnt), 32'd50);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_state", 32'(state), 32'd0);
    chk("async_rst_cyc", 32'(cyc_cnt), 32'd0);
    chk("async_rst_ovf_err", {ovf, err}, 32'd0);
    rst = 1'b0; br_instr = '0;
    tick();

    // Basic count: 20 branch cycles, 10 with misses on ch0/ch2, then halt.
    en = 1'b1; tick(); en = 1'b0;
    chk("run_entry_state", 32'(state), 32'd1);
    chk("run_entry_cyc", 32'(cyc_cnt), 32'd0);
    for (int i = 0; i < 20; i++) begin
      br_instr = 4'b1111;
      br_miss  = (i < 10) ? 4'b0101 : 4'b0000;
      tick();
    end
    br_instr = '0; br_miss = '0;
    chk("pre_halt_cyc", 32'(cyc_cnt), 32'd20);
    instr = 32'h0000_0073; tick(); instr = '0;
    chk("halt_state", 32'(state), 32'd2);
    chk("halt_cyc", 32'(cyc_cnt), 32'd21);
    tick(); chk("drain1_state", 32'(state), 32'd2);
    tick(); chk("drain2_state", 32'(state), 32'd2);
    tick(); chk("done_state", 32'(state), 32'd3);
    chk("done_cyc", 32'(cyc_cnt), 32'd24);
    tick(); chk("done_frozen_cyc", 32'(cyc_cnt), 32'd24);
    foreach (basic_tab[i]) rd(basic_tab[i].ch, basic_tab[i].sel, basic_tab[i].exp, basic_tab[i].nm);
    chk("basic_err", 32'(err), 32'd0);

    clr = 1'b1; tick(); clr = 1'b0;
    chk("clr_state", 32'(state), 32'd0);
    chk("clr_cyc", 32'(cyc_cnt), 32'd0);
    rd(2'd0, 2'd0, 0, "clr_ch0_br");

    // Windows, back-to-back reads with pre-update data, protocol error.
    en = 1'b1; tick(); en = 1'b0;
    foreach (win_tab[k]) begin
      br_instr = {3'b001, win_tab[k].miss0};
      br_miss  = {1'b0, win_tab[k].err2, 1'b0, win_tab[k].miss0};
      rd_req   = win_tab[k].req;
      rd_ch    = win_tab[k].ch;
      rd_sel   = win_tab[k].sel;
      tick();
      chk($sformatf("win_k%0d_vld", k), 32'(rd_vld), 32'(win_tab[k].req));
      if (win_tab[k].req) chk($sformatf("win_k%0d_data", k), 32'(rd_data), win_tab[k].exp);
    end
    br_instr = '0; br_miss = '0; rd_req = 1'b0;
    chk("proto_err", 32'(err), 32'd1);
    chk("win_ovf", 32'(ovf), 32'd0);

    // A request coincident with clr gets no response.
    clr = 1'b1; rd_req = 1'b1; rd_ch = 2'd1; rd_sel = 2'd0;
    tick();
    clr = 1'b0; rd_req = 1'b0;
    chk("clr_req_vld", 32'(rd_vld), 32'd0);
    chk("clr_req_data", 32'(rd_data), 32'd0);
    chk("clr_err", 32'(err), 32'd0);
    chk("clr_req_state", 32'(state), 32'd0);

    // Saturation: 300 branches on ch1; the 8-bit cycle counter saturates too
    // and reports through ovf_o[0].
    en = 1'b1; tick(); en = 1'b0;
    br_instr = 4'b0010;
    repeat (300) tick();
    br_instr = '0;
    chk("sat_ovf", 32'(ovf), 32'b0011);
    chk("sat_cyc", 32'(cyc_cnt), 32'd255);
    instr = 32'h0000_0073; tick(); instr = '0;
    repeat (3) tick();
    chk("sat_done_state", 32'(state), 32'd3);
    rd(2'd1, 2'd0, 255, "sat_ch1_br");
    rd(2'd0, 2'd0, 0, "sat_ch0_br");

    // Out-of-range channel on the 3-channel instance.
    rd_req = 1'b1; rd_ch = 2'd3; rd_sel = 2'd0;
    tick();
    rd_req = 1'b0;
    chk("oor_vld", 32'(u1_rd_vld), 32'd1);
    chk("oor_data", 32'(u1_rd_data), 32'd0);
    chk("oor_err", 32'(u1_err), 32'd1);
    chk("inrange_err", 32'(err), 32'd0);

    clr = 1'b1; tick(); clr = 1'b0;
    chk("sat_clr_ovf", 32'(ovf), 32'd0);
    chk("sat_clr_state", 32'(state), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
